// File: rtl/dostring_pkg.sv
// Shared types and constants for the LED-strip frame transmitter.
package dostring_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START_FRAME = 3'd1,
        ST_LED_FRAME   = 3'd2,
        ST_END_FRAME   = 3'd3,
        ST_DONE        = 3'd4
    } state_t;

    localparam int         START_BITS = 32;
    localparam logic [2:0] LED_HDR    = 3'b111;

    // One end-frame byte per 16 LEDs so the final clock edges reach the last LED.
    function automatic int end_frame_bytes(input int num_leds);
        return (num_leds + 15) / 16;
    endfunction

endpackage

// File: rtl/dostring_bit_clk.sv
// SPI mode-0 bit timer: sck low then high for CLK_DIV cycles each; bit_end_o on the last high cycle.
// hold_i freezes the timer (sck stays low); en_i low parks it at the start of a low phase.
module dostring_bit_clk #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic hold_i,
    output logic sck_o,
    output logic bit_end_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          last_cyc;

    assign last_cyc  = (cnt_q == CW'(CLK_DIV - 1));
    assign sck_o     = sck_q;
    assign bit_end_o = en_i & ~hold_i & sck_q & last_cyc;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (!hold_i) begin
            if (last_cyc) begin
                cnt_d = '0;
                sck_d = ~sck_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/dostring_frame_tx.sv
// Serialises one LED-strip update: 32 zero bits, NUM_LEDS pixel words, then end-frame ones.
// Pixels are pulled with valid/ready at word boundaries; a missing pixel freezes sck low.
module dostring_frame_tx
    import dostring_pkg::*;
#(
    parameter int NUM_LEDS = 60,
    parameter int CLK_DIV  = 4
) (
    input  logic       dostring_clk,
    input  logic       my_reset_n,
    input  logic       start,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [4:0] pix_bright,
    input  logic [7:0] pix_red,
    input  logic [7:0] pix_green,
    input  logic [7:0] pix_blue,
    output logic       busy,
    output logic       frame_done,
    output logic       mosi,
    output logic       sck
);

    localparam int         LW        = $clog2(NUM_LEDS + 1);
    localparam int         END_BYTES = end_frame_bytes(NUM_LEDS);
    localparam logic [4:0] LAST_BIT  = 5'(START_BITS - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    state_t        state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [LW-1:0] led_cnt_q, led_cnt_d;
    logic          need_load_q, need_load_d;
    logic          bit_en, bit_hold, bit_end;
    logic [31:0]   pix_word;

    // Assertion reaches every flop at once; release is retimed onto dostring_clk.
    always_ff @(posedge dostring_clk or negedge my_reset_n) begin
        if (!my_reset_n) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign bit_en    = (state_q == ST_START_FRAME) || (state_q == ST_LED_FRAME) ||
                       (state_q == ST_END_FRAME);
    assign bit_hold  = (state_q == ST_LED_FRAME) && need_load_q && !pix_valid;
    assign pix_ready = (state_q == ST_LED_FRAME) && need_load_q && pix_valid;
    assign pix_word  = {LED_HDR, pix_bright, pix_blue, pix_green, pix_red};

    assign busy       = bit_en;
    assign frame_done = (state_q == ST_DONE);
    // The load cycle is already the first low cycle of the word, so its MSB is shown directly.
    assign mosi       = pix_ready ? LED_HDR[2] : shift_q[31];

    dostring_bit_clk #(.CLK_DIV(CLK_DIV)) u_bit_clk (
        .clk_i     (dostring_clk),
        .rst_ni    (rst_n),
        .en_i      (bit_en),
        .hold_i    (bit_hold),
        .sck_o     (sck),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        led_cnt_d   = led_cnt_q;
        need_load_d = need_load_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_START_FRAME;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    led_cnt_d   = '0;
                    need_load_d = 1'b0;
                end
            end
            ST_START_FRAME: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = ST_LED_FRAME;
                        bit_cnt_d   = '0;
                        need_load_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[30:0], 1'b0};
                    end
                end
            end
            ST_LED_FRAME: begin
                if (pix_ready) begin
                    shift_d     = pix_word;
                    need_load_d = 1'b0;
                end
                // The last bit is not shifted out so mosi holds it through a stall.
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (led_cnt_q == LW'(NUM_LEDS - 1)) begin
                            state_d   = ST_END_FRAME;
                            led_cnt_d = '0;
                            shift_d   = '1;
                        end else begin
                            led_cnt_d   = led_cnt_q + LW'(1);
                            need_load_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[30:0], 1'b0};
                    end
                end
            end
            ST_END_FRAME: begin
                // led_cnt is reused here as the end-frame byte counter.
                if (bit_end) begin
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        if (led_cnt_q == LW'(END_BYTES - 1)) begin
                            state_d   = ST_DONE;
                            led_cnt_d = '0;
                            shift_d   = '0;
                        end else begin
                            led_cnt_d = led_cnt_q + LW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge dostring_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            led_cnt_q   <= '0;
            need_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            led_cnt_q   <= led_cnt_d;
            need_load_q <= need_load_d;
        end
    end

endmodule

// File: doc/dostring_frame_tx.md
DOSTRING_FRAME_TX -- requirements
Module: dostring_frame_tx

Interface
REQ-001 Parameter NUM_LEDS, default 60, is the number of LED frames per strip update (1..1023).
REQ-002 Parameter CLK_DIV, default 4, is the number of dostring_clk cycles per sck half-period (>=1).
REQ-003 dostring_clk  in  1  single clock for all logic.
REQ-004 my_reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a strip update.
REQ-006 pix_valid  in  1  pixel data present.
REQ-007 pix_ready  out  1  pixel accepted this cycle.
REQ-008 pix_bright  in  5  global brightness for the pixel.
REQ-009 pix_red, pix_green, pix_blue  in  8 each  colour channels.
REQ-010 busy  out  1  update in progress.
REQ-011 frame_done  out  1  one-cycle pulse at end of update.
REQ-012 mosi  out  1  serial data to strip.
REQ-013 sck  out  1  serial clock to strip.

Function
REQ-014 States SHALL be IDLE, START_FRAME, LED_FRAME, END_FRAME, DONE.
REQ-015 IDLE: start=1 -> START_FRAME next cycle, busy=1 from that cycle; start while busy SHALL be ignored.
REQ-016 Each bit SHALL occupy 2*CLK_DIV cycles: sck low for CLK_DIV cycles, then high for CLK_DIV; mosi SHALL change only when sck goes/stays low (SPI mode 0), MSB first.
REQ-017 START_FRAME SHALL shift 32 zero bits, then go to LED_FRAME.
REQ-018 LED_FRAME SHALL send NUM_LEDS 32-bit words, each {3'b111, pix_bright, pix_blue, pix_green, pix_red}, MSB first.
REQ-019 At each LED word boundary pix_ready SHALL be 1 for exactly the cycle in which pix_valid=1 is sampled; the word SHALL load into the shift register that same cycle.
REQ-020 If pix_valid=0 at a word boundary, sck SHALL hold 0 and mosi hold its value until pix_valid=1 (stall, no bit-timer advance).
REQ-021 pix_ready SHALL never be 1 outside LED_FRAME; exactly NUM_LEDS handshakes per update.
REQ-022 END_FRAME SHALL send 8*((NUM_LEDS+15)/16) one bits, then go to DONE.
REQ-023 DONE SHALL last one cycle with frame_done=1, busy=0 then, and sck=0, mosi=0; next state IDLE.
REQ-024 Unstalled update length SHALL be (32 + 32*NUM_LEDS + END_BITS)*2*CLK_DIV cycles from first busy cycle to DONE.
REQ-025 Bit counter SHALL be sized for 32 bits; LED counter SHALL be clog2(NUM_LEDS+1) bits and SHALL not wrap.
REQ-026 In IDLE sck=0, mosi=0.

Reset
REQ-027 my_reset_n=0 SHALL immediately force state IDLE, mosi=0, sck=0, busy=0, pix_ready=0, frame_done=0, all counters 0.
REQ-028 Reset asserted mid-update SHALL abandon the update; no frame_done pulse; after release the block SHALL wait for a new start.
REQ-029 Reset deassertion SHALL be synchronised to dostring_clk before use.

Structure
REQ-030 Package dostring_pkg SHALL hold the state enum, START_BITS=32, LED_HDR=3'b111, and the end-frame byte-count function.
REQ-031 Sub-module dostring_bit_clk SHALL generate sck and the bit-advance/mosi-update ticks from CLK_DIV, with a hold input for stalls.

Verification
REQ-032 NUM_LEDS=4, CLK_DIV=2, pix_valid tied 1, pixels bright=31 RGB=FF/00/80 -> decoded stream 32x0, four words 0xFF80_00FF, 8x1; frame_done after 672 busy cycles.
REQ-033 Stall: pix_valid=0 for 50 cycles at second word boundary -> sck held 0 for 50 cycles, total length 722, data unchanged.
REQ-034 start pulsed again during busy -> ignored, exactly one frame_done, exactly 4 pix_ready pulses.
REQ-035 my_reset_n low during LED_FRAME word 2 -> all outputs 0 same cycle; no frame_done; new start after release produces full correct frame.
REQ-036 CLK_DIV=1, NUM_LEDS=1 -> sck period 2 cycles, end frame 8 bits, length 144 cycles.
REQ-037 Protocol checker on all tests: mosi stable while sck=1, pix_ready only in LED_FRAME, busy and frame_done never both 1.
